decode_3_8bits: RTL and testbench



---
 rtl/decode_3_8bits_pkg.sv | 15 +
 rtl/decode_3_8bits.sv | 30 +++
 tb/tb_decode_3_8bits.sv | 119 +++++++++++
 3 files changed

// File: rtl/decode_3_8bits_pkg.sv
// Shared processor constants and the MSB-first register-select mapping
// used by the control unit, the register file and the select decoders.
package decode_3_8bits_pkg;

    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    // R0 occupies the MSB of a select vector; Rk lands on bit NUM_REGS-1-k.
    localparam logic [NUM_REGS-1:0] SEL_R0 = {1'b1, {(NUM_REGS-1){1'b0}}};

    function automatic logic [NUM_REGS-1:0] reg_select(input logic [REG_IDX_W-1:0] idx);
        return SEL_R0 >> idx;
    endfunction

endpackage

// File: rtl/decode_3_8bits.sv
// Register-select decoder: 3-bit register field to MSB-first one-hot enables,
// with a combinational output and a registered copy cleared by async reset.
module decode_3_8bits
    import decode_3_8bits_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [REG_IDX_W-1:0] W,
    input  logic                 En,
    output logic [NUM_REGS-1:0]  Y,
    output logic [NUM_REGS-1:0]  Yq
);

    always_comb begin
        Y = '0;
        if (En) begin
            Y = reg_select(W);
        end
    end

    // Resetn is active-high despite its name; the control unit drives it that way.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            Yq <= '0;
        end else begin
            Yq <= Y;
        end
    end

endmodule

// File: tb/tb_decode_3_8bits.sv
// Directed-vector bench for decode_3_8bits: combinational map, registered
// copy, asynchronous reset and enable timing around the clock edge.
module tb_decode_3_8bits;

    logic       Clock;
    logic       Resetn;
    logic [2:0] W;
    logic       En;
    logic [7:0] Y;
    logic [7:0] Yq;

    int n_tests;
    int n_fail;

    logic [7:0] exp_tbl [8];

    decode_3_8bits dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .W      (W),
        .En     (En),
        .Y      (Y),
        .Yq     (Yq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_tbl = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        Resetn = 1'b1;
        W      = 3'd0;
        En     = 1'b0;
        #1;
        check_val("reset_yq", Yq, 8'h00);

        // Exhaustive sweep, enabled
        for (int i = 0; i < 8; i++) begin
            W  = 3'(i);
            En = 1'b1;
            #1;
            check_val($sformatf("y_en1_w%0d", i), Y, exp_tbl[i]);
            check_val($sformatf("onehot_w%0d", i), 8'($countones(Y)), 8'd1);
        end

        // Disabled at every index
        for (int i = 0; i < 8; i++) begin
            W  = 3'(i);
            En = 1'b0;
            #1;
            check_val($sformatf("y_en0_w%0d", i), Y, 8'h00);
        end
        check_val("yq_held_in_reset", Yq, 8'h00);

        // Registered path
        @(negedge Clock);
        Resetn = 1'b0;
        W      = 3'b011;
        En     = 1'b1;
        @(posedge Clock);
        #1;
        check_val("yq_w3", Yq, 8'h10);
        W = 3'b110;
        #1;
        check_val("y_w6", Y, 8'h02);
        check_val("yq_hold_before_edge", Yq, 8'h10);
        @(posedge Clock);
        #1;
        check_val("yq_w6", Yq, 8'h02);

        // Asynchronous reset mid-cycle
        #2;
        Resetn = 1'b1;
        #1;
        check_val("yq_async_clear", Yq, 8'h00);
        W = 3'b101;
        repeat (2) @(posedge Clock);
        #1;
        check_val("yq_reset_hold", Yq, 8'h00);
        check_val("y_tracks_in_reset", Y, 8'h04);

        // Reset release
        @(negedge Clock);
        W      = 3'b000;
        En     = 1'b1;
        Resetn = 1'b0;
        #1;
        check_val("yq_before_release_edge", Yq, 8'h00);
        @(posedge Clock);
        #1;
        check_val("yq_after_release", Yq, 8'h80);

        // Enable dropped just before an edge
        @(negedge Clock);
        W  = 3'b010;
        En = 1'b1;
        #4;
        En = 1'b0;
        @(posedge Clock);
        #1;
        check_val("yq_en_pulse", Yq, 8'h00);
        check_val("y_en_pulse", Y, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
